unidade_controle_jogo: RTL and testbench

- Moore control unit for the sequence-memory game datapath. It drives two contador_limite instances: an address counter E (current play within the round) and a limit counter L (current round length).
- It consumes their end-of-count/compare status, the memory-vs-switch comparator, and a one-cycle "play made" pulse.
- It sequences rounds and ends the game in one of three terminal states: win, error or timeout.

---
 rtl/unidade_controle_pkg.sv | 67 ++++++
 rtl/unidade_controle_jogo_if.sv | 34 +++
 rtl/temporizador_jogada.sv | 35 +++
 rtl/unidade_controle_jogo.sv | 86 ++++++++
 tb/tb_unidade_controle_jogo.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the sequence-memory game control unit.
//   estado_t           : state encoding; the values double as db_estado debug codes
//   saidas_t           : registered counter-control and status outputs
//   decodifica_saidas  : Moore output decode for a given state
package unidade_controle_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 5000;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    INICIO_RODADA  = 4'd2,
    ESPERA         = 4'd3,
    REGISTRA       = 4'd4,
    COMPARA        = 4'd5,
    PROXIMA_JOGADA = 4'd6,
    PROXIMA_RODADA = 4'd7,
    FIM_ACERTO     = 4'd10,
    FIM_TIMEOUT    = 4'd13,
    FIM_ERRO       = 4'd14
  } estado_t;

  typedef struct packed {
    logic zera_e_n;
    logic conta_e;
    logic zera_l_n;
    logic conta_l;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Unused codes decode like INICIAL: nothing asserted, both clears released.
  function automatic saidas_t decodifica_saidas(input estado_t e);
    saidas_t s;
    s          = '0;
    s.zera_e_n = 1'b1;
    s.zera_l_n = 1'b1;
    case (e)
      PREPARA: begin
        s.zera_e_n = 1'b0;
        s.zera_l_n = 1'b0;
      end
      INICIO_RODADA:  s.zera_e_n   = 1'b0;
      REGISTRA:       s.registra_r = 1'b1;
      PROXIMA_JOGADA: s.conta_e    = 1'b1;
      PROXIMA_RODADA: s.conta_l    = 1'b1;
      FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Signal bundle between the game control unit and its datapath.
//   status in  : iniciar, jogada, igual, enderecoIgualLimite, fimL
//   control out: zeraE_n, contaE, zeraL_n, contaL, registraR
//   game status: pronto, acertou, errou, timeout, db_estado
// master = control unit, slave = datapath / environment.
interface unidade_controle_jogo_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       enderecoIgualLimite;
  logic       fimL;
  logic       zeraE_n;
  logic       contaE;
  logic       zeraL_n;
  logic       contaL;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, enderecoIgualLimite, fimL,
    output zeraE_n, contaE, zeraL_n, contaL, registraR,
    output pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, enderecoIgualLimite, fimL,
    input  zeraE_n, contaE, zeraL_n, contaL, registraR,
    input  pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/temporizador_jogada.sv
// Play timer: modulo-TIMEOUT up-counter used while waiting for a play.
//   clock, reset : clock and asynchronous active-high reset
//   clr          : synchronous clear (priority over en)
//   en           : count enable
//   fim          : count equals TIMEOUT-1
module temporizador_jogada #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT - 1);

  logic [W-1:0] contagem;

  // Count register; wraps at TIMEOUT-1 so it stays modulo-TIMEOUT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (clr) begin
      contagem <= '0;
    end else if (en) begin
      if (contagem == ULTIMO) contagem <= '0;
      else                    contagem <= contagem + W'(1);
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the sequence-memory game.
//   clock, reset : clock and asynchronous active-high reset (forces INICIAL)
//   bus (master) : datapath status in, counter controls and game status out
// Outputs are registered from the decode of the next state, so they always
// match the decode of the current state register.
module unidade_controle_jogo
  import unidade_controle_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_jogo_if.master bus
);

  estado_t estado;
  estado_t proximo;
  saidas_t saidas;
  saidas_t saidas_prox;
  logic    em_espera;
  logic    fim_tempo;

  assign em_espera = (estado == ESPERA);

  // Timer runs only in ESPERA and restarts from zero on every entry.
  temporizador_jogada #(.TIMEOUT(TIMEOUT)) u_temporizador (
    .clock (clock),
    .reset (reset),
    .clr   (!em_espera),
    .en    (em_espera),
    .fim   (fim_tempo)
  );

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
      saidas <= decodifica_saidas(INICIAL);
    end else begin
      estado <= proximo;
      saidas <= saidas_prox;
    end
  end

  // Next-state logic and output decode of the next state.
  always_comb begin
    proximo     = estado;
    saidas_prox = '0;
    case (estado)
      INICIAL:        if (bus.iniciar) proximo = PREPARA;
      PREPARA:        proximo = INICIO_RODADA;
      INICIO_RODADA:  proximo = ESPERA;
      ESPERA: begin
        // A play in the last allowed cycle still counts.
        if (bus.jogada)     proximo = REGISTRA;
        else if (fim_tempo) proximo = FIM_TIMEOUT;
      end
      REGISTRA:       proximo = COMPARA;
      COMPARA: begin
        if (!bus.igual)                          proximo = FIM_ERRO;
        else if (bus.enderecoIgualLimite && bus.fimL) proximo = FIM_ACERTO;
        else if (bus.enderecoIgualLimite)        proximo = PROXIMA_RODADA;
        else                                     proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA;
      PROXIMA_RODADA: proximo = INICIO_RODADA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT:    if (bus.iniciar) proximo = PREPARA;
      default:        proximo = INICIAL;
    endcase
    saidas_prox = decodifica_saidas(proximo);
  end

  assign bus.zeraE_n   = saidas.zera_e_n;
  assign bus.contaE    = saidas.conta_e;
  assign bus.zeraL_n   = saidas.zera_l_n;
  assign bus.contaL    = saidas.conta_l;
  assign bus.registraR = saidas.registra_r;
  assign bus.pronto    = saidas.pronto;
  assign bus.acertou   = saidas.acertou;
  assign bus.errou     = saidas.errou;
  assign bus.timeout   = saidas.timeout;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scoreboard bench for unidade_controle_jogo (TIMEOUT = 8).
// Each stimulus step pushes the state expected after the next clock edge;
// a monitor on the falling edge pops it and compares state plus all flags.
module tb_unidade_controle_jogo;
  import unidade_controle_pkg::*;

  localparam int unsigned TO = 8;

  logic clock = 1'b0;
  logic reset;

  unidade_controle_jogo_if bus ();

  unidade_controle_jogo #(.TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [3:0] estado;
  } esperado_t;

  esperado_t fila[$];
  int n_comp  = 0;
  int n_falha = 0;
  int n_passo = 0;

  // Required outputs per state code:
  // {db_estado, zeraE_n, contaE, zeraL_n, contaL, registraR, pronto, acertou, errou, timeout}
  function automatic logic [12:0] ref_saida(input logic [3:0] s);
    case (s)
      4'd0:    return {4'd0,  9'b1_0_1_0_0_0_0_0_0};
      4'd1:    return {4'd1,  9'b0_0_0_0_0_0_0_0_0};
      4'd2:    return {4'd2,  9'b0_0_1_0_0_0_0_0_0};
      4'd3:    return {4'd3,  9'b1_0_1_0_0_0_0_0_0};
      4'd4:    return {4'd4,  9'b1_0_1_0_1_0_0_0_0};
      4'd5:    return {4'd5,  9'b1_0_1_0_0_0_0_0_0};
      4'd6:    return {4'd6,  9'b1_1_1_0_0_0_0_0_0};
      4'd7:    return {4'd7,  9'b1_0_1_1_0_0_0_0_0};
      4'd10:   return {4'd10, 9'b1_0_1_0_0_1_1_0_0};
      4'd13:   return {4'd13, 9'b1_0_1_0_0_1_0_0_1};
      4'd14:   return {4'd14, 9'b1_0_1_0_0_1_0_1_0};
      default: return 13'h1fff;
    endcase
  endfunction

  // Monitor: compare whenever an expectation is pending.
  always @(negedge clock) begin : monitor
    esperado_t   e;
    logic [12:0] atual;
    logic [12:0] req;
    if (fila.size() > 0) begin
      e     = fila.pop_front();
      req   = ref_saida(e.estado);
      atual = {bus.db_estado, bus.zeraE_n, bus.contaE, bus.zeraL_n, bus.contaL,
               bus.registraR, bus.pronto, bus.acertou, bus.errou, bus.timeout};
      n_comp++;
      if (atual !== req) begin
        n_falha++;
        $display("FAIL step%0d: got estado=%0d flags=%b, required estado=%0d flags=%b",
                 e.id, atual[12:9], atual[8:0], req[12:9], req[8:0]);
      end
    end
  end

  task automatic zera_entradas();
    bus.iniciar             = 1'b0;
    bus.jogada              = 1'b0;
    bus.igual               = 1'b0;
    bus.enderecoIgualLimite = 1'b0;
    bus.fimL                = 1'b0;
  endtask

  task automatic espera(input logic [3:0] prox);
    esperado_t e;
    n_passo++;
    e.id     = n_passo;
    e.estado = prox;
    fila.push_back(e);
  endtask

  // Apply inputs for one clock edge and expect state prox after it.
  task automatic passo(input int rst_i, input int ini, input int jog, input int ig,
                       input int eq, input int fim, input int prox);
    @(negedge clock);
    #1;
    reset                   = (rst_i != 0);
    bus.iniciar             = (ini != 0);
    bus.jogada              = (jog != 0);
    bus.igual               = (ig != 0);
    bus.enderecoIgualLimite = (eq != 0);
    bus.fimL                = (fim != 0);
    espera(4'(prox));
  endtask

  // Raise reset in the middle of the high phase: no clock edge before the sample.
  task automatic reset_assincrono();
    @(negedge clock);
    #1;
    zera_entradas();
    @(posedge clock);
    #2;
    reset = 1'b1;
    espera(4'd0);
  endtask

  // Deposit an arbitrary code into the state register.
  task automatic deposita(input logic [3:0] cod);
    @(negedge clock);
    #1;
    reset = 1'b0;
    zera_entradas();
    dut.estado = estado_t'(cod);
    espera(4'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, required done");
    $fatal(1);
  end

  initial begin : estimulo
    reset = 1'b1;
    zera_entradas();

    // Reset and idle
    passo(1, 0, 0, 0, 0, 0, 0);
    passo(0, 0, 0, 0, 0, 0, 0);

    // Round 0: one correct play, advance round
    passo(0, 1, 0, 0, 0, 0, 1);
    passo(0, 0, 0, 0, 0, 0, 2);
    passo(0, 0, 0, 0, 0, 0, 3);
    passo(0, 0, 1, 0, 0, 0, 4);
    passo(0, 0, 0, 1, 1, 0, 5);
    passo(0, 0, 0, 1, 1, 0, 7);
    passo(0, 0, 0, 0, 0, 0, 2);
    passo(0, 0, 0, 0, 0, 0, 3);

    // Round 1: correct play then wrong play (igual=0 beats enderecoIgualLimite)
    passo(0, 0, 1, 0, 0, 0, 4);
    passo(0, 0, 0, 1, 0, 0, 5);
    passo(0, 0, 0, 1, 0, 0, 6);
    passo(0, 0, 0, 0, 0, 0, 3);
    passo(0, 0, 1, 0, 0, 0, 4);
    passo(0, 0, 0, 0, 0, 0, 5);
    passo(0, 0, 0, 0, 1, 0, 14);
    passo(0, 0, 1, 0, 0, 0, 14);

    // Reset mid-ESPERA, then a jogada in INICIAL is ignored
    passo(0, 1, 0, 0, 0, 0, 1);
    passo(0, 0, 0, 0, 0, 0, 2);
    passo(0, 0, 0, 0, 0, 0, 3);
    passo(0, 0, 0, 0, 0, 0, 3);
    reset_assincrono();
    passo(0, 0, 1, 0, 0, 0, 0);

    // Timeout: 8 cycles in ESPERA then FIM_TIMEOUT
    passo(0, 1, 0, 0, 0, 0, 1);
    passo(0, 0, 0, 0, 0, 0, 2);
    passo(0, 0, 0, 0, 0, 0, 3);
    repeat (TO - 1) passo(0, 0, 0, 0, 0, 0, 3);
    passo(0, 0, 0, 0, 0, 0, 13);
    passo(0, 0, 0, 0, 0, 0, 13);

    // Restart with iniciar held; jogada on the 8th ESPERA cycle wins
    passo(0, 1, 0, 0, 0, 0, 1);
    passo(0, 1, 0, 0, 0, 0, 2);
    passo(0, 1, 0, 0, 0, 0, 3);
    repeat (TO - 1) passo(0, 1, 0, 0, 0, 0, 3);
    passo(0, 1, 1, 0, 0, 0, 4);
    passo(0, 0, 0, 0, 0, 0, 5);
    passo(0, 0, 0, 0, 0, 0, 14);

    // Full win: 16 rounds, round r has r+1 plays, fimL high in round 15
    passo(0, 1, 0, 0, 0, 0, 1);
    passo(0, 0, 0, 0, 0, 0, 2);
    passo(0, 0, 0, 0, 0, 0, 3);
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p <= r; p++) begin
        passo(0, 0, 1, 0, 0, int'(r == 15), 4);
        passo(0, 0, 0, 1, int'(p == r), int'(r == 15), 5);
        if (p < r) begin
          passo(0, 0, 0, 1, 0, int'(r == 15), 6);
          passo(0, 0, 0, 0, 0, int'(r == 15), 3);
        end else if (r < 15) begin
          passo(0, 0, 0, 1, 1, 0, 7);
          passo(0, 0, 0, 0, 0, 0, 2);
          passo(0, 0, 0, 0, 0, 0, 3);
        end else begin
          passo(0, 0, 0, 1, 1, 1, 10);
        end
      end
    end
    passo(0, 0, 0, 0, 0, 0, 10);
    passo(0, 1, 0, 0, 0, 0, 1);
    passo(0, 0, 0, 0, 0, 0, 2);
    passo(0, 0, 0, 0, 0, 0, 3);

    // Illegal state codes return to INICIAL on the next edge
    deposita(4'd9);
    passo(0, 0, 0, 0, 0, 0, 0);
    passo(0, 1, 0, 0, 0, 0, 1);
    passo(0, 0, 0, 0, 0, 0, 2);
    deposita(4'd15);

    repeat (3) @(negedge clock);
    #1;
    n_comp++;
    if (fila.size() != 0) begin
      n_falha++;
      $display("FAIL drain: got %0d pending expectations, required 0", fila.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
    $finish;
  end

endmodule
